// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer, full flag and fill level for the async FIFO (optional level logic under FIFO_WR_LEVEL_EN)
module fifo_wptr_full #(
    parameter int DEPTH       = 8,
    parameter int PTRWIDTH    = $clog2(DEPTH),
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = DEPTH - 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                w_en,
    input  logic [PTRWIDTH:0]   g_rptr,
    output logic [PTRWIDTH:0]   b_wptr,
    output logic [PTRWIDTH:0]   g_wptr,
    output logic                full,
    output logic                almost_full,
    output logic [PTRWIDTH:0]   wr_level,
    output logic                overflow
);
    logic [PTRWIDTH:0] sync_q [SYNC_STAGES];
    logic [PTRWIDTH:0] g_rq;
    logic [PTRWIDTH:0] b_next;
    logic [PTRWIDTH:0] g_next;
    logic              wacc;

    assign g_rq   = sync_q[SYNC_STAGES-1];
    assign wacc   = w_en & ~full;
    assign b_next = b_wptr + {{PTRWIDTH{1'b0}}, wacc};
    assign g_next = b_next ^ (b_next >> 1);

    // bring the Gray read pointer into wclk through a plain flop chain
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= g_rptr;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // pointers, full (Gray compare with top two bits inverted) and sticky overflow
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            b_wptr   <= '0;
            g_wptr   <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            b_wptr   <= b_next;
            g_wptr   <= g_next;
            full     <= g_next == {~g_rq[PTRWIDTH:PTRWIDTH-1], g_rq[PTRWIDTH-2:0]};
            overflow <= overflow | (w_en & full);
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    localparam logic [PTRWIDTH:0] af_lvl = AF_LEVEL[PTRWIDTH:0];
    logic [PTRWIDTH:0] rq_bin;
    logic [PTRWIDTH:0] level_next;

    for (genvar i = 0; i <= PTRWIDTH; i++) begin : g_bin
        assign rq_bin[i] = ^g_rq[PTRWIDTH:i];
    end

    assign level_next = b_next - rq_bin;

    // conservative occupancy against the synchronised (stale) read pointer
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wr_level    <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_level    <= level_next;
            almost_full <= level_next >= af_lvl;
        end
    end
`else
    assign wr_level    = '0;
    assign almost_full = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: directed checks of pointers, full, overflow, level, wrap and reset
module tb_fifo_wptr_full;
    logic       wclk = 1'b0;
    logic       run  = 1'b0;
    logic       wrst = 1'b0;
    logic       w_en = 1'b0;
    logic [3:0] g_rptr = '0;
    logic [3:0] b_wptr, g_wptr, wr_level;
    logic       full, almost_full, overflow;
    int         checks = 0;
    int         errors = 0;
    int         n;

    fifo_wptr_full #(.DEPTH(8), .SYNC_STAGES(2), .AF_LEVEL(6)) dut (
        .wclk(wclk), .wrst(wrst), .w_en(w_en), .g_rptr(g_rptr),
        .b_wptr(b_wptr), .g_wptr(g_wptr), .full(full),
        .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
    );

    always begin
        #5;
        if (run) wclk = ~wclk;
    end

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " b_wptr"}, b_wptr, 0);
        chk({tag, " g_wptr"}, g_wptr, 0);
        chk({tag, " full"}, full, 0);
        chk({tag, " overflow"}, overflow, 0);
        chk({tag, " almost_full"}, almost_full, 0);
        chk({tag, " wr_level"}, wr_level, 0);
    endtask

    initial begin
        // reset with the clock stopped
        #1 wrst = 1'b1;
        #1 all_zero("rst_async");
        wrst = 1'b0;
        run  = 1'b1;
        tick();
        tick();
        all_zero("rst_idle");

        // fill to DEPTH with the reader parked at 0
        w_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("fill b_wptr", b_wptr, i);
            chk("fill full", full, i == 8);
`ifdef FIFO_WR_LEVEL_EN
            chk("fill almost_full", almost_full, i >= 6);
            chk("fill wr_level", wr_level, i);
`endif
        end
        chk("fill g_wptr", g_wptr, 4'b1100);

        // write attempted while full
        tick();
        chk("ovf b_wptr", b_wptr, 8);
        chk("ovf g_wptr", g_wptr, 4'b1100);
        chk("ovf flag", overflow, 1);
        w_en = 1'b0;
        tick();
        chk("ovf sticky", overflow, 1);

        // one read becomes visible on the third edge
        g_rptr = 4'b0001;
        tick();
        chk("rel full e1", full, 1);
        tick();
        chk("rel full e2", full, 1);
        tick();
        chk("rel full e3", full, 0);
`ifdef FIFO_WR_LEVEL_EN
        chk("rel wr_level", wr_level, 7);
        chk("rel almost_full", almost_full, 1);
`endif
        chk("rel b_wptr", b_wptr, 8);

        // clean reset before the wrap run
        wrst = 1'b1;
        g_rptr = '0;
        #2 wrst = 1'b0;
        tick();
        all_zero("rst_pre_wrap");

        // 20 writes with the reader trailing by two entries
        n = 0;
        w_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            chk("wrap b_wptr", b_wptr, n % 16);
            chk("wrap g_wptr", g_wptr, gray(4'(n % 16)));
            chk("wrap full", full, 0);
            if (n == 16) chk("wrap g_wptr zero", g_wptr, 4'b0000);
            if (n == 15) chk("wrap g_wptr top", g_wptr, 4'b1000);
            g_rptr = (n >= 2) ? gray(4'((n - 2) % 16)) : 4'b0000;
        end
        chk("wrap overflow", overflow, 0);
`ifdef FIFO_WR_LEVEL_EN
        chk("wrap almost_full", almost_full, 0);
`endif

        // reset mid-run with w_en held high
        tick();
        chk("mid b_wptr", b_wptr, 5);
        wrst = 1'b1;
        g_rptr = '0;
        #1 all_zero("mid_async");
        tick();
        chk("mid held b_wptr", b_wptr, 0);
        wrst = 1'b0;
        tick();
        chk("resume b_wptr", b_wptr, 1);
        chk("resume g_wptr", g_wptr, 1);
        chk("resume overflow", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
